up_count_monitor: RTL and testbench

Sequence monitor sitting directly downstream of the 4-bit synchronous up counter, on the same `clk` and `reset`. It samples the counter's output every cycle and checks that the value advances by exactly +1 mod 2^WIDTH. It reports wrap-around events and sequence errors, and keeps saturating statistics. It also tracks lock, dropping lock after repeated consecutive errors and re-synchronising on its own.

---
 rtl/up_count_mon_pkg.sv | 17 +
 rtl/up_count_monitor_sat_counter.sv | 44 ++++
 rtl/up_count_monitor.sv | 129 ++++++++++++
 tb/tb_up_count_monitor.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/up_count_mon_pkg.sv
// rtl/up_count_mon_pkg.sv - shared types and default constants for the up-count sequence monitor
//
// Purpose: holds the monitor FSM state type and the default parameter values
//          used by up_count_monitor.
// Ports:   none (package).
package up_count_mon_pkg;

  typedef enum logic {
    SYNC  = 1'b0,
    TRACK = 1'b1
  } mon_state_t;

  localparam int DEF_WIDTH      = 4;
  localparam int DEF_STAT_W     = 8;
  localparam int DEF_LOSS_LIMIT = 3;

endpackage

// File: rtl/up_count_monitor_sat_counter.sv
// rtl/up_count_monitor_sat_counter.sv - saturating event counter with priority clear
//
// Purpose: counts single-cycle increment requests, holds at all-ones instead of
//          wrapping. A clear in the same cycle as an increment wins, so that
//          event is dropped.
// Ports:
//   clk   in  1      rising-edge clock
//   reset in  1      synchronous active-high reset, clears the count
//   inc   in  1      increment request for this cycle
//   clr   in  1      synchronous clear, priority over inc
//   q     out W      current count
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/up_count_monitor.sv
// rtl/up_count_monitor.sv - checks that a counter advances by exactly +1 every cycle
//
// Purpose: samples count_in every cycle; in TRACK compares it with the previous
//          sample plus one (mod 2^WIDTH), flags wrap-arounds and mismatches,
//          keeps saturating statistics and drops lock after LOSS_LIMIT
//          consecutive mismatches, re-anchoring on its own from SYNC.
// Ports:
//   clk        in  1       rising-edge clock
//   reset      in  1       synchronous active-high reset
//   clr        in  1       clears wrap_cnt, err_cnt, err_sticky (not lock)
//   count_in   in  WIDTH   monitored counter value
//   locked     out 1       high while in TRACK
//   wrap_pulse out 1       one-cycle pulse on a legal all-ones -> 0 step
//   seq_err    out 1       one-cycle pulse on a sequence mismatch
//   err_sticky out 1       set by any mismatch, cleared by reset or clr
//   wrap_cnt   out STAT_W  saturating wrap count
//   err_cnt    out STAT_W  saturating error count
module up_count_monitor
  import up_count_mon_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int STAT_W     = DEF_STAT_W,
  parameter int LOSS_LIMIT = DEF_LOSS_LIMIT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic [WIDTH-1:0]  count_in,
  output logic              locked,
  output logic              wrap_pulse,
  output logic              seq_err,
  output logic              err_sticky,
  output logic [STAT_W-1:0] wrap_cnt,
  output logic [STAT_W-1:0] err_cnt
);

  mon_state_t       state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] expected;
  logic [3:0]       consec_q, consec_d;
  logic [3:0]       consec_inc;
  logic             wrap_pulse_q, wrap_pulse_d;
  logic             seq_err_q, seq_err_d;
  logic             err_sticky_q, err_sticky_d;

  always_comb begin
    state_d      = state_q;
    prev_d       = prev_q;
    consec_d     = consec_q;
    wrap_pulse_d = 1'b0;
    seq_err_d    = 1'b0;
    expected     = prev_q + WIDTH'(1);
    consec_inc   = consec_q + 4'd1;

    case (state_q)
      SYNC: begin
        // Anchor only; nothing is known about the previous value yet.
        prev_d   = count_in;
        consec_d = 4'd0;
        state_d  = TRACK;
      end
      TRACK: begin
        if (count_in == expected) begin
          prev_d       = count_in;
          consec_d     = 4'd0;
          wrap_pulse_d = (prev_q == '1) && (count_in == '0);
        end else begin
          // Re-anchor on the bad value so a single glitch costs two errors,
          // not a permanent offset.
          seq_err_d = 1'b1;
          prev_d    = count_in;
          if (consec_inc == 4'(LOSS_LIMIT)) begin
            state_d  = SYNC;
            consec_d = 4'd0;
          end else begin
            consec_d = consec_inc;
          end
        end
      end
      default: begin
        state_d = SYNC;
      end
    endcase

    // clr wins over a same-cycle error so that event is not recorded.
    err_sticky_d = clr ? 1'b0 : (err_sticky_q | seq_err_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= SYNC;
      prev_q       <= '0;
      consec_q     <= 4'd0;
      wrap_pulse_q <= 1'b0;
      seq_err_q    <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      consec_q     <= consec_d;
      wrap_pulse_q <= wrap_pulse_d;
      seq_err_q    <= seq_err_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  // Statistics update on the same edge as the pulse they count.
  sat_counter #(.W(STAT_W)) u_wrap_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (wrap_pulse_d),
    .clr   (clr),
    .q     (wrap_cnt)
  );

  sat_counter #(.W(STAT_W)) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (seq_err_d),
    .clr   (clr),
    .q     (err_cnt)
  );

  assign locked     = (state_q == TRACK);
  assign wrap_pulse = wrap_pulse_q;
  assign seq_err    = seq_err_q;
  assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_up_count_monitor.sv
// tb/tb_up_count_monitor.sv - directed self-checking bench for up_count_monitor
module tb_up_count_monitor;

  logic       clk;
  logic       reset;
  logic       clr;
  logic [3:0] count_in;

  logic       locked, wrap_pulse, seq_err, err_sticky;
  logic [7:0] wrap_cnt, err_cnt;

  logic       s_locked, s_wrap_pulse, s_seq_err, s_err_sticky;
  logic [1:0] s_wrap_cnt, s_err_cnt;

  int tests_run;
  int tests_failed;

  up_count_monitor #(.WIDTH(4), .STAT_W(8), .LOSS_LIMIT(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .clr        (clr),
    .count_in   (count_in),
    .locked     (locked),
    .wrap_pulse (wrap_pulse),
    .seq_err    (seq_err),
    .err_sticky (err_sticky),
    .wrap_cnt   (wrap_cnt),
    .err_cnt    (err_cnt)
  );

  up_count_monitor #(.WIDTH(4), .STAT_W(2), .LOSS_LIMIT(3)) dut_sat (
    .clk        (clk),
    .reset      (reset),
    .clr        (clr),
    .count_in   (count_in),
    .locked     (s_locked),
    .wrap_pulse (s_wrap_pulse),
    .seq_err    (s_seq_err),
    .err_sticky (s_err_sticky),
    .wrap_cnt   (s_wrap_cnt),
    .err_cnt    (s_err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Present one sample, clock it in, then settle past the edge before checking.
  task automatic tick(input logic [3:0] v, input logic c);
    count_in = v;
    clr      = c;
    @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    clr      = 1'b0;
    count_in = 4'd0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [3:0] v;
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    clr          = 1'b0;
    count_in     = 4'd0;
    #2;

    // Reset state
    do_reset();
    check_eq("rst_locked", locked, 0);
    check_eq("rst_wrap_pulse", wrap_pulse, 0);
    check_eq("rst_seq_err", seq_err, 0);
    check_eq("rst_err_sticky", err_sticky, 0);
    check_eq("rst_wrap_cnt", wrap_cnt, 0);
    check_eq("rst_err_cnt", err_cnt, 0);

    // Clean run: edge k samples (k-1) mod 16; wraps sampled at E17 and E33
    for (int k = 1; k <= 40; k++) begin
      v = 4'((k - 1) % 16);
      tick(v, 1'b0);
      check_eq("clean_locked", locked, 1);
      check_eq("clean_wrap_pulse", wrap_pulse, ((k == 17) || (k == 33)) ? 1 : 0);
      check_eq("clean_seq_err", seq_err, 0);
    end
    check_eq("clean_wrap_cnt", wrap_cnt, 2);
    check_eq("clean_err_cnt", err_cnt, 0);
    check_eq("clean_err_sticky", err_sticky, 0);

    // Single glitch: 3 anchors, 4 ok, 9 bad, 6 bad, 7 and 8 ok
    do_reset();
    tick(4'd3, 1'b0);
    check_eq("glitch_anchor_locked", locked, 1);
    tick(4'd4, 1'b0);
    check_eq("glitch_4_err", seq_err, 0);
    tick(4'd9, 1'b0);
    check_eq("glitch_9_err", seq_err, 1);
    check_eq("glitch_9_sticky", err_sticky, 1);
    tick(4'd6, 1'b0);
    check_eq("glitch_6_err", seq_err, 1);
    check_eq("glitch_6_locked", locked, 1);
    tick(4'd7, 1'b0);
    check_eq("glitch_7_err", seq_err, 0);
    tick(4'd8, 1'b0);
    check_eq("glitch_8_err", seq_err, 0);
    check_eq("glitch_err_cnt", err_cnt, 2);
    check_eq("glitch_err_sticky", err_sticky, 1);
    check_eq("glitch_locked", locked, 1);

    // Stuck value: 4, 5 ok, then five samples of 5
    do_reset();
    tick(4'd4, 1'b0);
    tick(4'd5, 1'b0);
    check_eq("stuck_pre_err", seq_err, 0);
    tick(4'd5, 1'b0);
    check_eq("stuck_1_err", seq_err, 1);
    check_eq("stuck_1_locked", locked, 1);
    tick(4'd5, 1'b0);
    check_eq("stuck_2_err", seq_err, 1);
    check_eq("stuck_2_locked", locked, 1);
    tick(4'd5, 1'b0);
    check_eq("stuck_3_err", seq_err, 1);
    check_eq("stuck_3_locked", locked, 0);
    tick(4'd5, 1'b0);
    check_eq("stuck_anchor_err", seq_err, 0);
    check_eq("stuck_anchor_locked", locked, 1);
    check_eq("stuck_err_cnt", err_cnt, 3);
    tick(4'd5, 1'b0);
    check_eq("stuck_5_err", seq_err, 1);
    check_eq("stuck_5_err_cnt", err_cnt, 4);

    // Clear precedence: build up an error, then clr on the 15 -> 0 sample
    do_reset();
    tick(4'd10, 1'b0);
    tick(4'd12, 1'b0);
    check_eq("clr_pre_sticky", err_sticky, 1);
    check_eq("clr_pre_err_cnt", err_cnt, 1);
    tick(4'd13, 1'b0);
    tick(4'd14, 1'b0);
    tick(4'd15, 1'b0);
    tick(4'd0, 1'b1);
    check_eq("clr_wrap_pulse", wrap_pulse, 1);
    check_eq("clr_wrap_cnt", wrap_cnt, 0);
    check_eq("clr_err_cnt", err_cnt, 0);
    check_eq("clr_err_sticky", err_sticky, 0);
    check_eq("clr_locked", locked, 1);
    // clr on a mismatch: pulse still seen, statistics untouched
    tick(4'd7, 1'b1);
    check_eq("clr_err_pulse", seq_err, 1);
    check_eq("clr_err_dropped", err_cnt, 0);
    check_eq("clr_sticky_dropped", err_sticky, 0);

    // Saturation: 80 clean cycles, wraps at E17, E33, E49, E65
    do_reset();
    for (int k = 1; k <= 80; k++) begin
      v = 4'((k - 1) % 16);
      tick(v, 1'b0);
      check_eq("sat_wrap_pulse", s_wrap_pulse, ((k > 1) && ((k % 16) == 1)) ? 1 : 0);
      if (k == 49) check_eq("sat_wrap_cnt_e49", s_wrap_cnt, 3);
    end
    check_eq("sat_wrap_cnt_end", s_wrap_cnt, 3);
    check_eq("sat_wide_wrap_cnt", wrap_cnt, 4);
    check_eq("sat_err_cnt", s_err_cnt, 0);

    // Mid-run reset at E25, counter resets with it
    do_reset();
    for (int k = 1; k <= 24; k++) begin
      v = 4'((k - 1) % 16);
      tick(v, 1'b0);
    end
    check_eq("mid_pre_locked", locked, 1);
    reset = 1'b1;
    tick(4'd8, 1'b1);
    reset = 1'b0;
    check_eq("mid_locked", locked, 0);
    check_eq("mid_wrap_pulse", wrap_pulse, 0);
    check_eq("mid_seq_err", seq_err, 0);
    check_eq("mid_err_sticky", err_sticky, 0);
    check_eq("mid_wrap_cnt", wrap_cnt, 0);
    check_eq("mid_err_cnt", err_cnt, 0);
    tick(4'd0, 1'b0);
    check_eq("mid_relock", locked, 1);
    check_eq("mid_relock_err", seq_err, 0);
    tick(4'd1, 1'b0);
    check_eq("mid_next_err", seq_err, 0);
    check_eq("mid_next_err_cnt", err_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
